hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the 5-stage pipeline, the successor to the single-cycle combinational load-use detector.
- Detects load-use hazards with a configurable stall length, ignores register 0 and unused source operands, freezes the pipeline while data memory is not ready, and flushes IF/ID on taken branches.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the ID stage and drives PC, IF/ID, ID/EX and EX/MEM control.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 42 ++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Contents : Shared state encoding, default widths and constants for hazard_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        MEMWAIT = 2'd2
    } state_e;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_LOAD_STALL = 1;
    localparam int DEF_CNT_W      = 16;

    // Wide enough for the largest legal stall length (7)
    localparam int REMAIN_W = 3;

    localparam int REG_ZERO = 0;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Contents : Up-counter that sticks at all-ones, with synchronous clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Contents : Load-use / memory-wait / branch-flush controller for the 5-stage
//            pipeline, with a saturating stall-cycle counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LOAD_STALL = DEF_LOAD_STALL,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  if_id_use_rs_i,
    input  logic                  if_id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
    input  logic                  id_ex_memread_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    input  logic                  branch_taken_i,
    output logic                  pc_hold_o,
    output logic                  if_id_hold_o,
    output logic                  id_ex_bubble_o,
    output logic                  if_id_flush_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    state_e                state_q,  state_d;
    state_e                saved_q,  saved_d;
    logic [REMAIN_W-1:0]   remain_q, remain_d;
    state_e                eff_state;

    logic load_use_hit;
    logic mem_wait;
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_bubble;
    logic if_id_flush;
    logic freeze;

    assign load_use_hit = id_ex_memread_i
                       && (id_ex_rd_i != REG_ADDR_W'(REG_ZERO))
                       && ((if_id_use_rs_i && (if_id_rs_i == id_ex_rd_i))
                        || (if_id_use_rt_i && (if_id_rt_i == id_ex_rd_i)));

    assign mem_wait = dmem_req_i && !dmem_ready_i;

    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        remain_d     = remain_q;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        freeze       = 1'b0;

        // The cycle the memory answers already behaves as the state we froze in
        eff_state = state_q;
        if ((state_q == MEMWAIT) && dmem_ready_i) begin
            eff_state = saved_q;
        end

        case (eff_state)
            MEMWAIT: begin
                freeze     = 1'b1;
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                state_d    = MEMWAIT;
            end

            STALL: begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = MEMWAIT;
                    saved_d = STALL;
                end else begin
                    id_ex_bubble = 1'b1;
                    if (remain_q <= REMAIN_W'(1)) begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end else begin
                        state_d  = STALL;
                        remain_d = remain_q - REMAIN_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                if (mem_wait) begin
                    freeze     = 1'b1;
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    state_d    = MEMWAIT;
                    saved_d    = IDLE;
                end else if (load_use_hit) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d  = STALL;
                        remain_d = REMAIN_W'(LOAD_STALL - 1);
                    end
                end else if (branch_taken_i) begin
                    if_id_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            saved_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            remain_q <= remain_d;
        end
    end

    // Outputs are quiet for the whole reset pulse, not just after the next edge
    assign pc_hold_o      = pc_hold      && !rst_i;
    assign if_id_hold_o   = if_id_hold   && !rst_i;
    assign id_ex_bubble_o = id_ex_bubble && !rst_i;
    assign if_id_flush_o  = if_id_flush  && !rst_i;
    assign freeze_o       = freeze       && !rst_i;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (pc_hold_o),
        .clear_i (1'b0),
        .cnt_o   (stall_cnt_o)
    );

endmodule : hazard_ctrl

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Contents : Self-checking bench for hazard_ctrl (three parameterisations)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       use_rs = 1'b0, use_rt = 1'b0, memread = 1'b0;
    logic       req = 1'b0, ready = 1'b0, br = 1'b0;

    // Control outputs packed as {pc_hold, if_id_hold, bubble, flush, freeze}
    logic [4:0]  ctrl [N];
    logic [15:0] cnt  [N];
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt), .id_ex_rd_i(rd),
        .id_ex_memread_i(memread), .dmem_req_i(req), .dmem_ready_i(ready),
        .branch_taken_i(br), .pc_hold_o(ctrl[0][4]), .if_id_hold_o(ctrl[0][3]),
        .id_ex_bubble_o(ctrl[0][2]), .if_id_flush_o(ctrl[0][1]),
        .freeze_o(ctrl[0][0]), .stall_cnt_o(cnt_a));

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(16)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt), .id_ex_rd_i(rd),
        .id_ex_memread_i(memread), .dmem_req_i(req), .dmem_ready_i(ready),
        .branch_taken_i(br), .pc_hold_o(ctrl[1][4]), .if_id_hold_o(ctrl[1][3]),
        .id_ex_bubble_o(ctrl[1][2]), .if_id_flush_o(ctrl[1][1]),
        .freeze_o(ctrl[1][0]), .stall_cnt_o(cnt_b));

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt),
        .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt), .id_ex_rd_i(rd),
        .id_ex_memread_i(memread), .dmem_req_i(req), .dmem_ready_i(ready),
        .branch_taken_i(br), .pc_hold_o(ctrl[2][4]), .if_id_hold_o(ctrl[2][3]),
        .id_ex_bubble_o(ctrl[2][2]), .if_id_flush_o(ctrl[2][1]),
        .freeze_o(ctrl[2][0]), .stall_cnt_o(cnt_c));

    assign cnt[0] = cnt_a;
    assign cnt[1] = cnt_b;
    assign cnt[2] = {12'd0, cnt_c};

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of stall still owed, and whether a memory wait is open
    typedef struct {
        int pend;
        bit waiting;
        int cnt;
    } mdl_t;

    mdl_t m  [N];
    mdl_t nx [N];
    int   ls   [N] = '{1, 3, 3};
    int   cmax [N] = '{65535, 65535, 15};

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       use_rs, use_rt, memread, req, ready, br;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [12];

    task automatic check_ctrl(input string name, input int i, input logic [4:0] exp);
        checks++;
        if (ctrl[i] !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: ctrl got %b expected %b", name, i, ctrl[i], exp);
        end
    endtask

    task automatic check_cnt(input string name, input int i, input int exp);
        checks++;
        if (cnt[i] !== 16'(exp)) begin
            errors++;
            $display("FAIL %s dut%0d: stall_cnt got %0d expected %0d", name, i, cnt[i], exp);
        end
    endtask

    task automatic idle_inputs();
        rs = '0; rt = '0; rd = '0; use_rs = 0; use_rt = 0; memread = 0;
        req = 0; ready = 0; br = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async pulse between edges; caller is at posedge+1
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            m[i].pend = 0; m[i].waiting = 0; m[i].cnt = 0;
        end
    endtask

    task automatic set_load_use(input logic [4:0] r);
        memread = 1; rd = r; rs = r; use_rs = 1;
    endtask

    task automatic model_eval(input int i, output logic [4:0] e, output mdl_t n);
        bit hit, frozen, hold;
        n = m[i];
        e = '0;
        hit = memread && (rd != 0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
        frozen = m[i].waiting ? !ready : (req && !ready);
        if (frozen) begin
            e = 5'b11001;
            n.waiting = 1;
        end else begin
            n.waiting = 0;
            if (m[i].pend > 0) begin
                e = 5'b11100;
                n.pend = m[i].pend - 1;
            end else if (hit) begin
                e = 5'b11100;
                n.pend = ls[i] - 1;
            end else if (br) begin
                e = 5'b00010;
            end
        end
        hold = e[4];
        if (hold && n.cnt < cmax[i]) n.cnt = n.cnt + 1;
    endtask

    initial begin
        vecs[0]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 0, 0, 5'b11100, "lu_rs"};
        vecs[1]  = '{5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 5'b00000, "lu_r0"};
        vecs[2]  = '{5'd0, 5'd9, 5'd9, 0, 0, 1, 0, 0, 0, 5'b00000, "lu_rt_unused"};
        vecs[3]  = '{5'd0, 5'd9, 5'd9, 0, 1, 1, 0, 0, 0, 5'b11100, "lu_rt"};
        vecs[4]  = '{5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 0, 0, 5'b00000, "no_load"};
        vecs[5]  = '{5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0, 1, 5'b00010, "branch"};
        vecs[6]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 0, 1, 5'b11100, "lu_and_branch"};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'b11001, "mem_wait"};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, 5'b00010, "mem_ready_same"};
        vecs[9]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 1, 0, 1, 5'b11001, "wait_over_lu"};
        vecs[10] = '{5'd7, 5'd0, 5'd8, 1, 0, 1, 0, 0, 0, 5'b00000, "lu_mismatch"};
        vecs[11] = '{5'd5, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 5'b11100, "lu_rt_only"};

        idle_inputs();
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check_ctrl("reset_ctrl", i, 5'b00000);
            check_cnt("reset_cnt", i, 0);
        end
        step();
        rst = 1'b0;
        step();

        // Single-cycle decisions from IDLE, each from a fresh reset
        for (int v = 0; v < 12; v++) begin
            idle_inputs();
            pulse_reset();
            rs = vecs[v].rs; rt = vecs[v].rt; rd = vecs[v].rd;
            use_rs = vecs[v].use_rs; use_rt = vecs[v].use_rt;
            memread = vecs[v].memread; req = vecs[v].req;
            ready = vecs[v].ready; br = vecs[v].br;
            #2;
            for (int i = 0; i < N; i++) check_ctrl(vecs[v].name, i, vecs[v].exp);
            step();
        end

        // Stall length: 1 for dut1, 3 for dut3
        idle_inputs(); pulse_reset();
        set_load_use(5'd8);
        #2;
        check_ctrl("len_c1", 0, 5'b11100); check_ctrl("len_c1", 1, 5'b11100);
        step(); idle_inputs(); #2;
        check_ctrl("len_c2", 0, 5'b00000); check_ctrl("len_c2", 1, 5'b11100);
        check_cnt("len_cnt1", 0, 1);
        step(); #2;
        check_ctrl("len_c3", 1, 5'b11100);
        step(); #2;
        check_ctrl("len_c4", 1, 5'b00000);
        check_cnt("len_cnt3", 1, 3);

        // Freeze in the middle of a 3-cycle stall
        step(); idle_inputs(); pulse_reset();
        set_load_use(5'd8);
        #2;
        check_ctrl("frz_c1", 1, 5'b11100);
        step(); idle_inputs(); req = 1; ready = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_ctrl("frz_wait", 1, 5'b11001);
            check_ctrl("frz_wait", 0, 5'b11001);
            step();
        end
        ready = 1; #2;
        check_ctrl("frz_resume", 1, 5'b11100);
        check_ctrl("frz_resume", 0, 5'b00000);
        step(); req = 0; ready = 0; #2;
        check_ctrl("frz_last", 1, 5'b11100);
        step(); #2;
        check_ctrl("frz_done", 1, 5'b00000);
        check_cnt("frz_cnt", 1, 7);
        check_cnt("frz_cnt", 0, 5);

        // Branch during a stall is ignored; in IDLE it flushes for one cycle
        step(); idle_inputs(); pulse_reset();
        set_load_use(5'd4); br = 1;
        #2;
        check_ctrl("br_hit", 1, 5'b11100);
        step(); idle_inputs(); br = 1; #2;
        check_ctrl("br_stall", 1, 5'b11100);
        check_ctrl("br_idle", 0, 5'b00010);
        step(); br = 0; #2;
        check_ctrl("br_pulse_end", 0, 5'b00000);

        // Async reset mid-STALL
        step(); idle_inputs(); pulse_reset();
        set_load_use(5'd6);
        step(); idle_inputs(); #1;
        check_ctrl("rst_pre", 1, 5'b11100);
        rst = 1'b1; #1;
        for (int i = 0; i < N; i++) begin
            check_ctrl("rst_mid", i, 5'b00000);
            check_cnt("rst_mid_cnt", i, 0);
        end
        step(); rst = 1'b0; #2;
        check_ctrl("rst_after", 1, 5'b00000);
        step();
        check_cnt("rst_after_cnt", 1, 0);

        // Saturation with a 4-bit counter
        idle_inputs(); pulse_reset();
        set_load_use(5'd3);
        for (int k = 0; k < 20; k++) step();
        idle_inputs(); #2;
        check_cnt("sat_cnt4", 2, 15);
        check_cnt("sat_cnt16", 0, 20);

        // Randomized run against the model
        step(); idle_inputs(); pulse_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] e;
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom); use_rt = 1'($urandom);
            memread = 1'($urandom);
            req = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 3) == 0);
            #2;
            for (int i = 0; i < N; i++) begin
                model_eval(i, e, nx[i]);
                check_ctrl("rand_ctrl", i, e);
                check_cnt("rand_cnt", i, m[i].cnt);
            end
            step();
            for (int i = 0; i < N; i++) m[i] = nx[i];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_hazard_ctrl

`default_nettype wire
